// File: rtl/instr_prefetch_unit.sv
// Instruction prefetch unit: fetches sequential 32-bit words from instruction
// memory into a DEPTH-entry FIFO of {address, instruction} and presents the
// head to decode. Redirects flush the FIFO and restart fetching at a new PC.
// Optional feature macro: PREFETCH_ALIGN_CHECK_EN adds fault_o and halts
// fetching on a misaligned redirect until the next aligned redirect.
module instr_prefetch_unit #(
   parameter int unsigned        ADDR_W     = 32,
   parameter int unsigned        DEPTH      = 4,
   parameter logic [ADDR_W-1:0]  RESET_ADDR = '0
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              instr_mem_ready_i,
   input  logic [31:0]       instr_mem_data_i,
   output logic [ADDR_W-1:0] instr_mem_addr_o,
   output logic              instr_mem_rd_o,
   input  logic              redirect_i,
   input  logic [ADDR_W-1:0] redirect_addr_i,
   output logic              instr_valid_o,
   input  logic              instr_ready_i,
   output logic [31:0]       instr_o,
   output logic [ADDR_W-1:0] instr_addr_o
`ifdef PREFETCH_ALIGN_CHECK_EN
   ,
   output logic              fault_o
`endif
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_DROP = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   pc_q, pc_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                rd_q, rd_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
   logic                valid_q, valid_d;
   logic                halt_q, halt_d;

   logic                push;
   logic                pop;
   logic                go_req;
   logic [ADDR_W-1:0]   redir_addr;
   logic                misaligned;

   logic [ADDR_W-1:0]   addr_mem [DEPTH];
   logic [31:0]         data_mem [DEPTH];

`ifdef PREFETCH_ALIGN_CHECK_EN
   assign redir_addr = redirect_addr_i;
   assign misaligned = (redirect_addr_i[1:0] != 2'b00);
   assign fault_o    = halt_q;
`else
   assign redir_addr = redirect_addr_i & ~ADDR_W'(3);
   assign misaligned = 1'b0;
`endif

   // Next-state logic: FIFO bookkeeping, fetch PC, and request FSM.
   // Redirect wins over push/pop; the FSM decision uses the post-update count
   // so a full buffer being drained keeps a request in flight every cycle.
   always_comb begin
      push     = 1'b0;
      pop      = 1'b0;
      state_d  = state_q;
      pc_d     = pc_q;
      addr_d   = addr_q;
      cnt_d    = cnt_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      halt_d   = halt_q;

      if (redirect_i) begin
         cnt_d    = '0;
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         pc_d     = redir_addr;
         halt_d   = misaligned;
      end else begin
         push = (state_q == S_REQ) && instr_mem_ready_i;
         pop  = valid_q && instr_ready_i;
         if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            pc_d     = pc_q + ADDR_W'(4);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
         endcase
      end

      go_req = (cnt_d < CNT_W'(DEPTH)) && !halt_d;

      case (state_q)
         S_IDLE: begin
            if (go_req) begin
               state_d = S_REQ;
               addr_d  = pc_d;
            end
         end
         S_REQ, S_DROP: begin
            if (instr_mem_ready_i) begin
               state_d = go_req ? S_REQ : S_IDLE;
               addr_d  = pc_d;
            end else if (redirect_i) begin
               state_d = S_DROP;
            end
         end
         default: state_d = S_IDLE;
      endcase

      rd_d    = (state_d != S_IDLE);
      valid_d = (cnt_d != '0);
   end

   // Control state, fetch PC and registered memory-side outputs.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= S_IDLE;
         pc_q     <= RESET_ADDR;
         addr_q   <= RESET_ADDR;
         rd_q     <= 1'b0;
         cnt_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         valid_q  <= 1'b0;
         halt_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         addr_q   <= addr_d;
         rd_q     <= rd_d;
         cnt_q    <= cnt_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         valid_q  <= valid_d;
         halt_q   <= halt_d;
      end
   end

   // FIFO storage; contents are never observed while the entry is invalid.
   always_ff @(posedge clk_i) begin
      if (push) begin
         addr_mem[wr_ptr_q] <= pc_q;
         data_mem[wr_ptr_q] <= instr_mem_data_i;
      end
   end

   assign instr_mem_addr_o = addr_q;
   assign instr_mem_rd_o   = rd_q;
   assign instr_valid_o    = valid_q;
   assign instr_o          = valid_q ? data_mem[rd_ptr_q] : '0;
   assign instr_addr_o     = valid_q ? addr_mem[rd_ptr_q] : '0;

endmodule

// File: tb/tb_instr_prefetch_unit.sv
// Testbench for instr_prefetch_unit: directed scenarios plus a randomized
// phase, all checked against a stream-level reference model of the fetch
// sequence (expected push/pop addresses, occupancy, stale-read tracking).
module tb_instr_prefetch_unit;

   localparam int unsigned ADDR_W     = 32;
   localparam int unsigned DEPTH      = 4;
   localparam logic [31:0] RESET_ADDR = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_ready;
   logic [31:0] mem_data;
   logic [31:0] mem_addr;
   logic        mem_rd;
   logic        redirect;
   logic [31:0] raddr;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [31:0] instr_addr;
`ifdef PREFETCH_ALIGN_CHECK_EN
   logic        fault;
`endif

   instr_prefetch_unit #(
      .ADDR_W     (ADDR_W),
      .DEPTH      (DEPTH),
      .RESET_ADDR (RESET_ADDR)
   ) dut (
      .clk_i             (clk),
      .rst_i             (rst),
      .instr_mem_ready_i (mem_ready),
      .instr_mem_data_i  (mem_data),
      .instr_mem_addr_o  (mem_addr),
      .instr_mem_rd_o    (mem_rd),
      .redirect_i        (redirect),
      .redirect_addr_i   (raddr),
      .instr_valid_o     (instr_valid),
      .instr_ready_i     (instr_ready),
      .instr_o           (instr),
      .instr_addr_o      (instr_addr)
`ifdef PREFETCH_ALIGN_CHECK_EN
      ,
      .fault_o           (fault)
`endif
   );

   always #5 clk = ~clk;

   int          n_pass = 0;
   int          n_total = 0;
   int          occ = 0;
   int          pops_seen = 0;
   logic [31:0] exp_push = RESET_ADDR;
   logic [31:0] exp_pop  = RESET_ADDR;
   bit          stale = 1'b0;
   bit          halted = 1'b0;

   function automatic logic [31:0] data_of(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
   endfunction

   function automatic logic [31:0] norm(input logic [31:0] a);
`ifdef PREFETCH_ALIGN_CHECK_EN
      return a;
`else
      return a & 32'hFFFF_FFFC;
`endif
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total = n_total + 1;
      assert (obs === exp) n_pass = n_pass + 1;
      else begin
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: update the model from the inputs and the outputs seen
   // before the edge, then compare the DUT's post-edge outputs to the model.
   task automatic step();
      logic        prev_rd;
      logic        prev_ready;
      logic [31:0] prev_addr;
      bit          hs;
      bit          exp_rd;
      mem_data   = data_of(mem_addr);
      prev_rd    = mem_rd;
      prev_ready = mem_ready;
      prev_addr  = mem_addr;
      hs         = mem_rd && mem_ready;
      if (rst) begin
         occ = 0; exp_push = RESET_ADDR; exp_pop = RESET_ADDR;
         stale = 1'b0; halted = 1'b0;
      end else begin
         if (instr_valid && instr_ready && !redirect) begin
            chk("pop_addr", instr_addr, exp_pop);
            chk("pop_data", instr, data_of(exp_pop));
            exp_pop = exp_pop + 32'd4;
            occ = occ - 1;
            pops_seen = pops_seen + 1;
         end
         if (hs) begin
            if (redirect || stale) stale = 1'b0;
            else begin
               chk("push_addr", mem_addr, exp_push);
               exp_push = exp_push + 32'd4;
               occ = occ + 1;
            end
         end else if (mem_rd && redirect) begin
            stale = 1'b1;
         end
         if (redirect) begin
            occ = 0;
            exp_push = norm(raddr);
            exp_pop  = norm(raddr);
`ifdef PREFETCH_ALIGN_CHECK_EN
            halted = (raddr[1:0] != 2'b00);
`endif
         end
      end
      @(posedge clk);
      #1;
      if (rst) begin
         chk("rst_rd", mem_rd, 0);
         chk("rst_valid", instr_valid, 0);
         chk("rst_instr", instr, 0);
         chk("rst_instr_addr", instr_addr, 0);
`ifdef PREFETCH_ALIGN_CHECK_EN
         chk("rst_fault", fault, 0);
`endif
      end else begin
         chk("valid", instr_valid, occ != 0);
         if (prev_rd && !prev_ready) begin
            chk("hold_rd", mem_rd, 1);
            chk("hold_addr", mem_addr, prev_addr);
         end else begin
            exp_rd = (occ < DEPTH) && !halted;
            chk("rd", mem_rd, exp_rd);
            if (exp_rd) chk("req_addr", mem_addr, exp_push);
         end
`ifdef PREFETCH_ALIGN_CHECK_EN
         chk("fault", fault, halted);
`endif
      end
   endtask

   initial begin
      rst = 1'b1; mem_ready = 1'b0; mem_data = '0; redirect = 1'b0;
      raddr = '0; instr_ready = 1'b0;

      // Reset state
      repeat (3) step();

      // Fill from reset with memory always ready: 0,4,8,C then stop
      mem_ready = 1'b1;
      rst = 1'b0;
      step();
      chk("first_rd", mem_rd, 1);
      chk("first_addr", mem_addr, 32'h0);
      repeat (6) step();
      chk("fill_stop_rd", mem_rd, 0);
      chk("fill_valid", instr_valid, 1);
      chk("fill_head", instr_addr, 32'h0);

      // Full buffer drained and refilled every cycle
      instr_ready = 1'b1;
      pops_seen = 0;
      repeat (10) step();
      chk("full_throughput", pops_seen, 10);

      // Redirect to 0x100 while a read waits 3 cycles
      mem_ready = 1'b0; instr_ready = 1'b0;
      step();
      redirect = 1'b1; raddr = 32'h100;
      step();
      redirect = 1'b0;
      chk("drop_valid", instr_valid, 0);
      step();
      mem_ready = 1'b1;
      step();
      chk("redir_rd", mem_rd, 1);
      chk("redir_addr", mem_addr, 32'h100);
      chk("redir_valid", instr_valid, 0);

      // Redirect coincident with memory ready and a pop
      repeat (2) step();
      instr_ready = 1'b1; redirect = 1'b1; raddr = 32'h300;
      step();
      redirect = 1'b0; instr_ready = 1'b0;
      chk("coinc_valid", instr_valid, 0);
      chk("coinc_addr", mem_addr, 32'h300);

      // PC wraparound at the top of the address space
      redirect = 1'b1; raddr = 32'hFFFF_FFF8;
      step();
      redirect = 1'b0; instr_ready = 1'b1;
      repeat (8) step();
      instr_ready = 1'b0;

`ifdef PREFETCH_ALIGN_CHECK_EN
      // Misaligned redirect halts fetch; aligned redirect resumes
      mem_ready = 1'b1;
      redirect = 1'b1; raddr = 32'h102;
      step();
      redirect = 1'b0;
      repeat (3) step();
      chk("mis_fault", fault, 1);
      chk("mis_rd", mem_rd, 0);
      redirect = 1'b1; raddr = 32'h200;
      step();
      redirect = 1'b0;
      chk("resume_fault", fault, 0);
      chk("resume_addr", mem_addr, 32'h200);
      // Misaligned redirect while a read is pending: finish the read, then halt
      mem_ready = 1'b0;
      redirect = 1'b1; raddr = 32'h206;
      step();
      redirect = 1'b0;
      step();
      mem_ready = 1'b1;
      step();
      chk("mis_drop_rd", mem_rd, 0);
      redirect = 1'b1; raddr = 32'h0;
      step();
      redirect = 1'b0;
`endif

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         mem_ready   = ($urandom_range(0, 99) < 70);
         instr_ready = ($urandom_range(0, 99) < 60);
         redirect    = ($urandom_range(0, 99) < 3);
         raddr       = $urandom;
         if ($urandom_range(0, 3) != 0) raddr = raddr & 32'hFFFF_FFFC;
         if ($urandom_range(0, 7) == 0) raddr = raddr | 32'hFFFF_FFE0;
         rst         = ($urandom_range(0, 499) == 0);
         step();
      end
      rst = 1'b0; redirect = 1'b0; instr_ready = 1'b0; mem_ready = 1'b1;

      // Asynchronous reset with a full buffer
      redirect = 1'b1; raddr = 32'h40;
      step();
      redirect = 1'b0;
      repeat (8) step();
      chk("pre_rst_valid", instr_valid, 1);
      rst = 1'b1;
      #1;
      chk("async_valid", instr_valid, 0);
      chk("async_instr", instr, 0);
      chk("async_instr_addr", instr_addr, 0);
      chk("async_rd", mem_rd, 0);
      step();
      rst = 1'b0;
      step();

      // Asynchronous reset in the middle of a dropped read
      mem_ready = 1'b0;
      redirect = 1'b1; raddr = 32'h500;
      step();
      redirect = 1'b0;
      step();
      chk("drop_pending_rd", mem_rd, 1);
      rst = 1'b1;
      #1;
      chk("drop_rst_rd", mem_rd, 0);
      chk("drop_rst_valid", instr_valid, 0);
`ifdef PREFETCH_ALIGN_CHECK_EN
      chk("drop_rst_fault", fault, 0);
`endif
      step();
      rst = 1'b0;
      step();
      chk("restart_rd", mem_rd, 1);
      chk("restart_addr", mem_addr, RESET_ADDR);
      mem_ready = 1'b1; instr_ready = 1'b1;
      repeat (6) step();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/instr_prefetch_unit.md
INSTR_PREFETCH_UNIT -- requirements
Module: instr_prefetch_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning the fetch address width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, meaning prefetch buffer entries; legal values are powers of 2 from 2 to 16.
REQ-003 SHALL have parameter RESET_ADDR, default 0, meaning the first fetch address after reset.
REQ-004 clk_i  input  1  clock; the only clock; all state updates on the rising edge.
REQ-005 rst_i  input  1  reset; asynchronous, active-high.
REQ-006 instr_mem_ready_i  input  1  memory has completed the current read; data is valid this cycle.
REQ-007 instr_mem_data_i  input  32  read data.
REQ-008 instr_mem_addr_o  output  ADDR_W  fetch address.
REQ-009 instr_mem_rd_o  output  1  read request.
REQ-010 redirect_i  input  1  jump/branch taken; flush and refetch.
REQ-011 redirect_addr_i  input  ADDR_W  new fetch address.
REQ-012 instr_valid_o  output  1  buffer head valid.
REQ-013 instr_ready_i  input  1  decode accepts the head.
REQ-014 instr_o  output  32  head instruction.
REQ-015 instr_addr_o  output  ADDR_W  head instruction address.
REQ-016 fault_o  output  1  misaligned redirect; present only with PREFETCH_ALIGN_CHECK_EN.

Function
REQ-017 SHALL keep a fetch PC, a DEPTH-entry FIFO of {address, instruction}, and a count of 0..DEPTH.
REQ-018 SHALL implement three states: IDLE (no request), REQ (rd_o=1, addr_o=PC), and DROP (rd_o=1, holding a stale address, data to be discarded).
REQ-019 SHALL hold instr_mem_addr_o and instr_mem_rd_o stable in REQ/DROP until a cycle with instr_mem_ready_i=1; there is at most one outstanding read.
REQ-020 IDLE->REQ SHALL occur when count<DEPTH and the unit is not halted.
REQ-021 In REQ with ready_i=1, the unit SHALL push {PC, data}, set PC+=4, and go to REQ if post-push count<DEPTH, else IDLE.
REQ-022 Pop SHALL occur when instr_valid_o & instr_ready_i; push and pop in the same cycle SHALL be allowed with count unchanged, including when full.
REQ-023 instr_valid_o SHALL equal (count!=0); the first instruction SHALL appear the cycle after its ready_i, with no combinational memory-to-output path.
REQ-024 redirect_i SHALL have priority over push and pop: count:=0, pop ignored, PC:=redirect_addr_i.
REQ-025 A redirect in REQ without ready_i SHALL go to DROP, keeping the old address on instr_mem_addr_o until ready_i, then discard the data and go to REQ at the new PC.
REQ-026 A redirect in the same cycle as ready_i SHALL discard the data and go to REQ at the new PC next cycle.
REQ-027 A redirect in DROP SHALL only update PC and remain in DROP.
REQ-028 PC SHALL wrap modulo 2^ADDR_W.

Reset
REQ-029 On rst_i=1 the unit SHALL immediately set state=IDLE, PC=RESET_ADDR, count=0, pointers=0, rd_o=0, valid_o=0, fault_o=0, instr_o=0, instr_addr_o=0.
REQ-030 The unit SHALL reach REQ on the first rising edge after rst_i falls.
REQ-031 Reset in REQ/DROP SHALL abandon the outstanding read without waiting for ready_i.

Configuration
REQ-032 With PREFETCH_ALIGN_CHECK_EN defined, a redirect with redirect_addr_i[1:0]!=0 SHALL flush, set fault_o=1, and halt fetching (IDLE, or after DROP completes) until the next aligned redirect, which clears fault_o.
REQ-033 Without PREFETCH_ALIGN_CHECK_EN, fault_o SHALL be absent, and redirect_addr_i[1:0] SHALL be forced to 0.

Verification
REQ-034 Reset release with ready_i=1 and ready_i held 1, DEPTH=4 -> rd_o rises 1 cycle after release; addresses 0,4,8,C; fetching stops when count=4.
REQ-035 Full buffer with instr_ready_i=1 and ready_i=1 every cycle -> one push and one pop per cycle, count stays 4, addresses in order.
REQ-036 Redirect to 0x100 while REQ is waiting 3 cycles for ready_i -> old address held until ready, data discarded, next request at 0x100, valid_o=0 in between.
REQ-037 Redirect coincident with ready_i and pop -> no push, no pop, count=0, next addr_o=redirect_addr_i.
REQ-038 With PREFETCH_ALIGN_CHECK_EN, redirect to 0x102 -> fault_o=1, rd_o=0; a following redirect to 0x200 -> fault_o=0 and fetch resumes at 0x200.
REQ-039 Assert rst_i mid-DROP -> all outputs reach their reset values in the same cycle; after release, fetch restarts at RESET_ADDR.
